// File: rtl/pmp_dmp.sv
`default_nettype none
// ============================================================================
//  Module      : pmp_dmp
//  Description : PMP region/permission checker with per-entry domain tags and
//                a registered allow decision (1-cycle latency).
//  Revision    : 1.0
// ============================================================================
module pmp_dmp #(
   parameter int PLEN       = 56,
   parameter int PMP_LEN    = 54,
   parameter int NR_ENTRIES = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [PLEN-1:0]                addr_i,
   input  logic [2:0]                     access_type_i,
   input  logic [1:0]                     priv_lvl_i,
   input  logic [1:0]                     curdom_i,
   input  logic [NR_ENTRIES*PMP_LEN-1:0]  conf_addr_i,
   input  logic [NR_ENTRIES*8-1:0]        pmpconf_i,
   input  logic [NR_ENTRIES*8-1:0]        dmpconf_i,
   output logic                           allow_o
);

   localparam int         AW          = (PLEN > PMP_LEN + 2) ? PLEN : PMP_LEN + 2;
   localparam logic [1:0] c_mode_tor   = 2'd1;
   localparam logic [1:0] c_mode_na4   = 2'd2;
   localparam logic [1:0] c_mode_napot = 2'd3;
   localparam logic [1:0] c_priv_m     = 2'd3;
   localparam logic [1:0] c_dom_i      = 2'd3;

   logic w_allow;
   logic r_allow;

   generate
      if (NR_ENTRIES == 0) begin : g_no_entries
         logic w_unused_ports;
         assign w_unused_ports = ^{addr_i, access_type_i, priv_lvl_i, curdom_i,
                                   conf_addr_i, pmpconf_i, dmpconf_i};
         assign w_allow = 1'b1;
      end else begin : g_entries
         logic [NR_ENTRIES-1:0]           w_match;
         logic [NR_ENTRIES-1:0]           w_ok;
         logic [NR_ENTRIES-1:0]           w_locked;
         logic [NR_ENTRIES-1:0][PLEN-1:0] w_top;

         for (genvar i = 0; i < NR_ENTRIES; i++) begin : g_entry
            logic [PMP_LEN-1:0] w_conf;
            logic [7:0]         w_pcfg;
            logic [7:0]         w_dcfg;
            logic [AW-1:0]      w_addr_ext;
            logic [AW-1:0]      w_mask_ext;
            logic [PLEN-1:0]    w_prev;
            logic [PLEN-1:0]    w_care;
            logic               w_tor_hit;
            logic               w_na4_hit;
            logic               w_napot_hit;
            logic               w_pmp_ok;
            logic               w_dom_ok;
            logic               w_unused_cfg;

            assign w_conf     = conf_addr_i[i*PMP_LEN +: PMP_LEN];
            assign w_pcfg     = pmpconf_i[i*8 +: 8];
            assign w_dcfg     = dmpconf_i[i*8 +: 8];
            assign w_addr_ext = AW'({w_conf, 2'b00});
            assign w_top[i]   = w_addr_ext[PLEN-1:0];
            // Don't-care bits of a NAPOT region; sign extension makes an
            // all-ones pmpaddr cover every address bit, even beyond PMP_LEN+2.
            assign w_mask_ext = AW'($signed({w_conf ^ (w_conf + PMP_LEN'(1)), 2'b11}));
            assign w_care     = w_mask_ext[PLEN-1:0];

            if (i == 0) begin : g_first
               assign w_prev = '0;
            end else begin : g_chain
               assign w_prev = w_top[i-1];
            end

            assign w_tor_hit   = (addr_i >= w_prev) && (addr_i < w_top[i]);
            assign w_na4_hit   = (addr_i[PLEN-1:2] == w_top[i][PLEN-1:2]);
            assign w_napot_hit = (((addr_i ^ w_top[i]) & ~w_care) == '0);

            assign w_match[i] = ((w_pcfg[4:3] == c_mode_tor)   && w_tor_hit)
                             || ((w_pcfg[4:3] == c_mode_na4)   && w_na4_hit)
                             || ((w_pcfg[4:3] == c_mode_napot) && w_napot_hit);

            assign w_pmp_ok = ((access_type_i & w_pcfg[2:0]) == access_type_i);
            assign w_dom_ok = (curdom_i == c_dom_i) || (w_dcfg[1:0] == c_dom_i)
                           || (curdom_i == w_dcfg[1:0]);

            assign w_ok[i]     = w_pmp_ok && w_dom_ok;
            assign w_locked[i] = w_pcfg[7];

            assign w_unused_cfg = ^{w_pcfg[6:5], w_dcfg[7:2], w_addr_ext, w_mask_ext};
         end

         // Walk from the highest index down so the lowest matching entry wins.
         always_comb begin
            w_allow = (priv_lvl_i == c_priv_m);
            for (int j = NR_ENTRIES - 1; j >= 0; j--) begin
               if (w_match[j]) begin
                  if ((priv_lvl_i == c_priv_m) && !w_locked[j]) begin
                     w_allow = 1'b1;
                  end else begin
                     w_allow = w_ok[j];
                  end
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_allow <= 1'b0;
      end else begin
         r_allow <= w_allow;
      end
   end

   assign allow_o = r_allow;

endmodule
`default_nettype wire

// File: tb/tb_pmp_dmp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pmp_dmp
//  Description : Directed self-checking bench for pmp_dmp (PLEN=16 build).
//  Revision    : 1.0
// ============================================================================
module tb_pmp_dmp;

   localparam int PLEN = 16;
   localparam int PMP_LEN = 14;
   localparam int NR = 4;

   logic                  clk;
   logic                  rst_n;
   logic [PLEN-1:0]       addr;
   logic [2:0]            acc;
   logic [1:0]            priv;
   logic [1:0]            curdom;
   logic [NR*PMP_LEN-1:0] conf_addr;
   logic [NR*8-1:0]       pmpconf;
   logic [NR*8-1:0]       dmpconf;
   logic                  allow;

   int errors = 0;
   int checks = 0;

   pmp_dmp #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .addr_i        (addr),
      .access_type_i (acc),
      .priv_lvl_i    (priv),
      .curdom_i      (curdom),
      .conf_addr_i   (conf_addr),
      .pmpconf_i     (pmpconf),
      .dmpconf_i     (dmpconf),
      .allow_o       (allow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_entry(input int idx, input logic [PMP_LEN-1:0] a,
                            input logic [7:0] pc, input logic [7:0] dc);
      conf_addr[idx*PMP_LEN +: PMP_LEN] = a;
      pmpconf[idx*8 +: 8] = pc;
      dmpconf[idx*8 +: 8] = dc;
   endtask

   task automatic clear_entries();
      conf_addr = '0;
      pmpconf   = '0;
      dmpconf   = '0;
   endtask

   task automatic test_reset();
      clear_entries();
      set_entry(0, 14'h065F, 8'h1F, 8'h00);
      priv = 2'd0; curdom = 2'd0; acc = 3'b001; addr = 16'h19BA;
      rst_n = 1'b0;
      cycle();
      checks++;
      if (allow !== 1'b0) begin
         errors++; $display("FAIL reset_hold: allow=%b expected=0", allow);
      end
      rst_n = 1'b1;
      cycle();
      checks++;
      if (allow !== 1'b1) begin
         errors++; $display("FAIL reset_release: allow=%b expected=1", allow);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (allow !== 1'b0) begin
         errors++; $display("FAIL reset_async: allow=%b expected=0", allow);
      end
      rst_n = 1'b1;
      cycle();
      checks++;
      if (allow !== 1'b1) begin
         errors++; $display("FAIL reset_recover: allow=%b expected=1", allow);
      end
   endtask

   task automatic test_domain_matrix(input logic [7:0] pcfg, input logic [15:0] expv,
                                     input string tag);
      clear_entries();
      priv = 2'd0; acc = 3'b001; addr = 16'h19BA;
      for (int c = 0; c < 4; c++) begin
         for (int d = 0; d < 4; d++) begin
            set_entry(0, 14'h065F, pcfg, 8'(d));
            curdom = 2'(c);
            cycle();
            checks++;
            if (allow !== expv[c*4+d]) begin
               errors++;
               $display("FAIL %s cur=%0d dom=%0d: allow=%b expected=%b",
                        tag, c, d, allow, expv[c*4+d]);
            end
         end
      end
   endtask

   task automatic test_priority();
      logic [15:0] addrs [4] = '{16'h0800, 16'h1800, 16'h0FFF, 16'h1000};
      logic        expv  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      clear_entries();
      set_entry(0, 14'h0400, 8'h09, 8'h00);
      set_entry(1, 14'h3FFF, 8'h1F, 8'h03);
      priv = 2'd0; curdom = 2'd1; acc = 3'b001;
      for (int k = 0; k < 4; k++) begin
         addr = addrs[k];
         cycle();
         checks++;
         if (allow !== expv[k]) begin
            errors++;
            $display("FAIL priority addr=%h: allow=%b expected=%b", addrs[k], allow, expv[k]);
         end
      end
      curdom = 2'd0; addr = 16'h0800; acc = 3'b010;
      cycle();
      checks++;
      if (allow !== 1'b0) begin
         errors++; $display("FAIL priority_write: allow=%b expected=0", allow);
      end
   endtask

   task automatic test_tor_chain();
      logic [15:0] addrs [4] = '{16'h1000, 16'h0FFF, 16'h17FF, 16'h1800};
      logic        expv  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      clear_entries();
      set_entry(0, 14'h0400, 8'h00, 8'h00);
      set_entry(1, 14'h0600, 8'h09, 8'h01);
      priv = 2'd1; curdom = 2'd1; acc = 3'b001;
      for (int k = 0; k < 4; k++) begin
         addr = addrs[k];
         cycle();
         checks++;
         if (allow !== expv[k]) begin
            errors++;
            $display("FAIL tor_chain addr=%h: allow=%b expected=%b", addrs[k], allow, expv[k]);
         end
      end
   endtask

   task automatic test_mmode();
      logic [7:0] pcfgs [5] = '{8'h00, 8'h1C, 8'h9C, 8'h9F, 8'h9F};
      logic [1:0] doms  [5] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1};
      logic       expv  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      clear_entries();
      priv = 2'd3; curdom = 2'd1; acc = 3'b001; addr = 16'h19BA;
      for (int k = 0; k < 5; k++) begin
         set_entry(0, 14'h065F, pcfgs[k], 8'(doms[k]));
         cycle();
         checks++;
         if (allow !== expv[k]) begin
            errors++;
            $display("FAIL mmode case=%0d: allow=%b expected=%b", k, allow, expv[k]);
         end
      end
   endtask

   task automatic test_off_na4();
      logic [15:0] addrs [4] = '{16'h19BA, 16'h19BC, 16'h19B8, 16'h19B7};
      logic        expv  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      clear_entries();
      priv = 2'd0; curdom = 2'd0; acc = 3'b001; addr = 16'h19BA;
      set_entry(0, 14'h065F, 8'h07, 8'h00);
      cycle();
      checks++;
      if (allow !== 1'b0) begin
         errors++; $display("FAIL off_entry: allow=%b expected=0", allow);
      end
      set_entry(0, 14'h066E, 8'h17, 8'h00);
      for (int k = 0; k < 4; k++) begin
         addr = addrs[k];
         cycle();
         checks++;
         if (allow !== expv[k]) begin
            errors++;
            $display("FAIL na4 addr=%h: allow=%b expected=%b", addrs[k], allow, expv[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_entries();
      set_entry(0, 14'h066E, 8'h17, 8'h02);
      priv = 2'd1; curdom = 2'd2; acc = 3'b100; addr = 16'h19B9;
      cycle();
      checks++;
      if (allow !== 1'b1) begin
         errors++; $display("FAIL b2b_first: allow=%b expected=1", allow);
      end
      addr = 16'h19C0;
      #1;
      checks++;
      if (allow !== 1'b1) begin
         errors++; $display("FAIL b2b_latency: allow=%b expected=1", allow);
      end
      cycle();
      checks++;
      if (allow !== 1'b0) begin
         errors++; $display("FAIL b2b_second: allow=%b expected=0", allow);
      end
      addr = 16'h19BB;
      cycle();
      checks++;
      if (allow !== 1'b1) begin
         errors++; $display("FAIL b2b_third: allow=%b expected=1", allow);
      end
   endtask

   initial begin
      logic [15:0] dom_exp;
      dom_exp = 16'b1111_1100_1010_1001;
      test_reset();
      test_domain_matrix(8'h1F, dom_exp, "dom_matrix");
      test_domain_matrix(8'h1C, 16'h0000, "xonly_matrix");
      test_priority();
      test_tor_chain();
      test_mmode();
      test_off_na4();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
